// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4: receive side of a 4-channel bit-interleaved TDM serial link.
// Recovers frame alignment from SYNC, steers each valid serial sample into its
// channel shift register and presents the four WIDTH-bit words in parallel
// with a one-cycle OUT_VALID strobe.
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds a 5th even-parity slot per
// frame and drives PAR_ERR; word completion moves to the parity slot).
module tdm_demux_1_4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               DIN,
  input  logic               VALID,
  input  logic               SYNC,
  output logic [4*WIDTH-1:0] OUT,
  output logic               OUT_VALID,
  output logic [2:0]         SEL,
  output logic               LOCKED,
  output logic               SYNC_ERR,
  output logic               PAR_ERR
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
`ifdef TDM_DEMUX_PARITY_EN
  localparam logic [2:0] SLOT_LAST = 3'd4;
`else
  localparam logic [2:0] SLOT_LAST = 3'd3;
`endif

  typedef enum logic {
    HUNT,
    RUN
  } state_t;

  state_t           state;
  logic [2:0]       slot;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-1:0] ch [4];
  logic [4*WIDTH-1:0] word_done;
`ifdef TDM_DEMUX_PARITY_EN
  logic             par;
`endif

  // SEL mirrors the transmitter's mux select: the slot of the next sample.
  assign SEL = slot;

`ifndef TDM_DEMUX_PARITY_EN
  assign PAR_ERR = 1'b0;
`endif

  // Completed word as it will look after the completing edge; without parity
  // that edge also carries the last ch3 bit, so it is merged in here.
  always_comb begin
    word_done = '0;
`ifdef TDM_DEMUX_PARITY_EN
    word_done = {ch[3], ch[2], ch[1], ch[0]};
`else
    word_done = {ch[3][WIDTH-2:0], DIN, ch[2], ch[1], ch[0]};
`endif
  end

  // Framing FSM, channel shift registers, word assembly and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      slot      <= '0;
      bitcnt    <= '0;
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      LOCKED    <= 1'b0;
      SYNC_ERR  <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) ch[k] <= '0;
`ifdef TDM_DEMUX_PARITY_EN
      PAR_ERR   <= 1'b0;
      par       <= 1'b0;
`endif
    end else begin
      OUT_VALID <= 1'b0;
      SYNC_ERR  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      PAR_ERR   <= 1'b0;
`endif
      if (VALID) begin
        case (state)
          HUNT: begin
            if (SYNC) begin
              ch[0]  <= {{(WIDTH-1){1'b0}}, DIN};
              ch[1]  <= '0;
              ch[2]  <= '0;
              ch[3]  <= '0;
              slot   <= 3'd1;
              bitcnt <= '0;
              state  <= RUN;
              LOCKED <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
              par    <= DIN;
`endif
            end
          end
          RUN: begin
            if (slot == 3'd0) begin
              if (SYNC) begin
                ch[0] <= {ch[0][WIDTH-2:0], DIN};
                slot  <= 3'd1;
`ifdef TDM_DEMUX_PARITY_EN
                par   <= DIN;
`endif
              end else begin
                // Lost alignment: drop the sample and go back to hunting.
                SYNC_ERR <= 1'b1;
                for (int unsigned k = 0; k < 4; k++) ch[k] <= '0;
                slot     <= '0;
                bitcnt   <= '0;
                state    <= HUNT;
                LOCKED   <= 1'b0;
              end
            end else if (SYNC) begin
              // Early marker: realign so this sample becomes slot 0, frame 0.
              SYNC_ERR <= 1'b1;
              ch[0]    <= {{(WIDTH-1){1'b0}}, DIN};
              ch[1]    <= '0;
              ch[2]    <= '0;
              ch[3]    <= '0;
              slot     <= 3'd1;
              bitcnt   <= '0;
`ifdef TDM_DEMUX_PARITY_EN
              par      <= DIN;
`endif
            end else begin
              for (int unsigned k = 1; k < 4; k++) begin
                if (slot == 3'(k)) ch[k] <= {ch[k][WIDTH-2:0], DIN};
              end
`ifdef TDM_DEMUX_PARITY_EN
              par <= par ^ DIN;
`endif
              if (slot == SLOT_LAST) begin
                slot <= '0;
`ifdef TDM_DEMUX_PARITY_EN
                if (par ^ DIN) PAR_ERR <= 1'b1;
`endif
                if (bitcnt == BIT_LAST) begin
                  bitcnt    <= '0;
                  OUT       <= word_done;
                  OUT_VALID <= 1'b1;
                end else begin
                  bitcnt <= bitcnt + 1'b1;
                end
              end else begin
                slot <= slot + 3'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
